// File: rtl/regfile_read_stage_if.sv
// ----------------------------------------------------------------------------
// regfile_read_stage_if
//   Bundles the write port, the read-request handshake and the registered
//   operand handshake of regfile_read_stage.
//
//   master : the side that writes registers, issues read requests and
//            consumes operand pairs (core / testbench)
//   slave  : the register file read stage itself
//
//   Signals
//     wr_en, wr_addr, wr_data   write port (index 0 is ignored by the stage)
//     req_valid / req_ready     read-request handshake
//     rd_addr_a, rd_addr_b      source register indices for operands A and B
//     out_valid / out_ready     operand-pair handshake toward the logic units
//     out_a, out_b              registered operands
// ----------------------------------------------------------------------------
interface regfile_read_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;

  modport master (
    output wr_en, wr_addr, wr_data,
    output req_valid, rd_addr_a, rd_addr_b,
    output out_ready,
    input  req_ready, out_valid, out_a, out_b
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  req_valid, rd_addr_a, rd_addr_b,
    input  out_ready,
    output req_ready, out_valid, out_a, out_b
  );
endinterface

// File: rtl/regfile_read_stage.sv
// ----------------------------------------------------------------------------
// regfile_read_stage
//   2**ADDR_W x DATA_W register file (one write port, two read ports) with a
//   registered operand-fetch stage feeding the OR/AND logic units.
//
//   Ports
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset; clears the register file, the
//            operand register, the stored source indices and out_valid
//     bus    regfile_read_stage_if.slave (write port, request handshake,
//            operand handshake)
//
//   Behaviour summary
//     - register 0 always reads as zero; writes to it are dropped
//     - a read of the register being written in the same cycle returns the
//       write data (bypass)
//     - the operand register holds one pair; it can be consumed and reloaded
//       on the same edge for one pair per cycle
//     - while a pair is stalled, a write to one of its source registers
//       refreshes the stalled operand so the logic units never see stale data
// ----------------------------------------------------------------------------
module regfile_read_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_read_stage_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  // Read-port resolution: hardwired zero, then same-cycle bypass, then storage.
  function automatic logic [DATA_W-1:0] resolve_read(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              wr_live,
    input logic [ADDR_W-1:0] wr_addr,
    input logic [DATA_W-1:0] wr_data
  );
    logic [DATA_W-1:0] val;
    val = stored;
    if (addr == '0)
      val = '0;
    else if (wr_live && (wr_addr == addr))
      val = wr_data;
    return val;
  endfunction

  logic [DATA_W-1:0] regs [DEPTH];

  logic [0:0]        state_p1;
  logic [DATA_W-1:0] a_p1;
  logic [DATA_W-1:0] b_p1;
  logic [ADDR_W-1:0] src_a_p1;
  logic [ADDR_W-1:0] src_b_p1;
  logic              vld_p1;

  logic              wr_live;
  logic              accept;
  logic              consume;
  logic [DATA_W-1:0] rd_a_p0;
  logic [DATA_W-1:0] rd_b_p0;

  assign vld_p1  = (state_p1 == FULL);
  // Writes to register 0 never take effect, so they also never bypass/refresh.
  assign wr_live = bus.wr_en && (bus.wr_addr != '0);

  // Ready depends only on stage state and downstream ready, never on req_valid.
  assign bus.req_ready = !vld_p1 || bus.out_ready;
  assign accept        = bus.req_valid && bus.req_ready;
  assign consume       = vld_p1 && bus.out_ready;

  // ---- stage p0: combinational register-file read with bypass ----
  always_comb begin
    rd_a_p0 = resolve_read(bus.rd_addr_a, regs[bus.rd_addr_a],
                           bus.wr_en, bus.wr_addr, bus.wr_data);
    rd_b_p0 = resolve_read(bus.rd_addr_b, regs[bus.rd_addr_b],
                           bus.wr_en, bus.wr_addr, bus.wr_data);
  end

  // Register file storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (wr_live) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // ---- stage p1: registered operand pair and its source indices ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p1 <= EMPTY;
      a_p1     <= '0;
      b_p1     <= '0;
      src_a_p1 <= '0;
      src_b_p1 <= '0;
    end else if (accept) begin
      state_p1 <= FULL;
      a_p1     <= rd_a_p0;
      b_p1     <= rd_b_p0;
      src_a_p1 <= bus.rd_addr_a;
      src_b_p1 <= bus.rd_addr_b;
    end else if (consume) begin
      // Operands keep their last value; only the valid flag drops.
      state_p1 <= EMPTY;
    end else if (vld_p1 && wr_live) begin
      // Stalled pair: follow writes to its own source registers.
      if (bus.wr_addr == src_a_p1)
        a_p1 <= bus.wr_data;
      if (bus.wr_addr == src_b_p1)
        b_p1 <= bus.wr_data;
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_a     = a_p1;
  assign bus.out_b     = b_p1;

endmodule

// File: doc/regfile_read_stage.md
Name: regfile_read_stage

Overview:
- Register file plus registered operand-fetch stage that directly feeds the two-input bitwise logic units (OR/AND) with their A and B operands.
- Holds 2**ADDR_W words, one write port, two read ports.
- Read results are captured into an output register with a valid/ready handshake, so the downstream logic stage can stall.
- Includes write-to-read bypass and a hazard refresh of stalled operands.

Parameters:
DATA_W, 32, width of each register and of the A/B operands
ADDR_W, 5, register address width; depth = 2**ADDR_W; register 0 is hardwired zero

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
wr_en  input  1  write strobe
wr_addr  input  ADDR_W  write register index
wr_data  input  DATA_W  write data
req_valid  input  1  read request present
req_ready  output  1  stage can accept a request this cycle
rd_addr_a  input  ADDR_W  source register for operand A
rd_addr_b  input  ADDR_W  source register for operand B
out_valid  output  1  out_a/out_b hold a valid operand pair
out_ready  input  1  downstream logic stage consumes the pair this cycle
out_a  output  DATA_W  operand A (registered)
out_b  output  DATA_W  operand B (registered)

Behaviour:
- Reset (rst_n=0 at an edge):
  - all registers cleared to 0; out_valid=0; out_a=0; out_b=0; stored source addresses cleared to 0.
  - Reset takes precedence over any write or request in the same cycle.
  - An in-flight or stalled pair is discarded.
- req_ready = !out_valid || out_ready. Combinational from state and out_ready only; it never depends on req_valid.
- Accept: req_valid && req_ready at an edge.
  - Latches out_a = read(rd_addr_a) and out_b = read(rd_addr_b).
  - Latches both source addresses; sets out_valid=1.
  - Latency: 1 cycle, request to out_valid.
- Consume without new accept (out_valid && out_ready && !req_valid): out_valid→0; out_a/out_b keep their last value.
- Back-to-back: consume and accept in the same edge loads the new pair and keeps out_valid=1. Full throughput is 1 pair/cycle.
- read(addr) definition:
  - addr==0 → 0.
  - Else if wr_en && wr_addr==addr → wr_data (same-cycle bypass).
  - Else the stored register.
- Write: wr_en && wr_addr!=0 updates the register at the edge. Writes to index 0 are ignored. Writes proceed regardless of handshake state.
- Stall refresh: while out_valid && !out_ready, a write (wr_en, wr_addr!=0) whose address matches the stored source address of A (or B) replaces out_a (or out_b) with wr_data at that edge. Both are updated if both match.
- When out_valid=0, no refresh occurs.
- Data is never dropped. While out_valid && !out_ready, out_a/out_b/out_valid change only through stall refresh.
- Stage state machine:
  - EMPTY (out_valid=0) → FULL on accept.
  - FULL → EMPTY on consume without accept.
  - FULL → FULL on stall or on consume+accept.
- All arithmetic is on unsigned indices; no wrap or overflow.

Test Plan:
- Reset/zero read: hold rst_n=0 for 2 cycles, release, request a=5, b=0 → out_valid=1 one cycle later, out_a=0, out_b=0; before the request, req_ready=1 and out_valid=0.
- Write then read with bypass: write r3=0x0000_00F0 while requesting a=3, b=3 in the same cycle → next cycle out_a=out_b=0x0000_00F0. Write r0=0xFFFF_FFFF, then request a=0 → out_a=0.
- Stall and hold: load pair (r1=0xA5A5_A5A5, r2=0x5A5A_5A5A), hold out_ready=0 for 4 cycles → req_ready=0, out values stable; raise out_ready → out_valid drops the next cycle if no new request.
- Stall refresh: pair stalled with source a=1; write r1=0x1234_5678 → out_a=0x1234_5678 at that edge, out_b unchanged. A write to r7 leaves both outputs unchanged.
- Back-to-back streaming: req_valid=1 and out_ready=1 for 8 cycles with addresses 1..8 (r_n=n preloaded) → out_valid stays 1 and out_a steps 1..8 one per cycle with no bubbles.
- Reset mid-stall: stalled pair present, assert rst_n=0 for one cycle concurrent with wr_en to r4=0x77 → out_valid=0, out_a=0, and reading r4 afterwards returns 0.
